snake_move_scheduler: RTL and testbench

- Sequences snake movement and sits between the key-direction decoder and the snake body/position engine.
- Generates periodic move ticks and samples the current one-hot direction at each tick.
- Issues each move to the engine through a req/ack handshake and runs the game-level FSM (idle, run, pause, over).
- Optionally raises game speed as food is eaten.

---
 rtl/snake_pkg.sv | 26 ++
 rtl/snake_tick_gen.sv | 36 +++
 rtl/snake_move_scheduler.sv | 165 ++++++++++++++++
 tb/tb_snake_move_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game blocks: one-hot direction codes
// (as produced by the key-direction decoder), game-state encodings and a
// direction validity helper.
package snake_pkg;

  typedef enum logic [3:0] {
    DIR_NONE  = 4'b1111,
    DIR_DOWN  = 4'b0001,
    DIR_UP    = 4'b0010,
    DIR_RIGHT = 4'b0100,
    DIR_LEFT  = 4'b1000
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_OVER  = 2'b11
  } game_state_e;

  // Only a single cardinal direction may ever be committed to a move.
  function automatic logic dir_valid(input logic [3:0] d);
    return (d == DIR_DOWN) || (d == DIR_UP) || (d == DIR_RIGHT) || (d == DIR_LEFT);
  endfunction

endpackage

// File: rtl/snake_tick_gen.sv
// Move-tick generator: a free-running counter that wraps at period-1 and
// emits a one-clock tick. The period register is reloaded only on a tick,
// so a new period_in takes effect from the following interval.
module snake_tick_gen #(
  parameter int CNT_W     = 24,
  parameter int TICK_BASE = 12500000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] period_in,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period_q;

  assign tick = enable && (cnt_q == (period_q - CNT_W'(1)));

  // Counter and period register; clear holds the counter at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      period_q <= CNT_W'(TICK_BASE);
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q    <= '0;
      period_q <= period_in;
    end else if (enable) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/snake_move_scheduler.sv
// Snake move scheduler: game FSM (idle/run/pause/over), periodic move
// ticks, and a req/ack move handshake towards the body/position engine.
// Optional speed-up with eaten food is enabled by defining SNAKE_SPEEDUP_EN.
module snake_move_scheduler
  import snake_pkg::*;
#(
  parameter int TICK_BASE       = 12500000,
  parameter int TICK_STEP       = 1000000,
  parameter int TICK_MIN        = 2500000,
  parameter int FOODS_PER_LEVEL = 4,
  parameter int MAX_LEVEL       = 15,
  parameter int CNT_W           = 24
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] direction,
  input  logic       pause,
  input  logic       food_eaten,
  input  logic       collision,
  input  logic       move_ack,
  output logic       move_req,
  output logic [3:0] move_dir,
  output logic [1:0] game_state,
  output logic [3:0] level,
  output logic       overrun
);

  localparam int PERIOD_W = CNT_W + 4;

  game_state_e      state_q, state_d;
  logic             req_q, req_d;
  logic [3:0]       dir_q, dir_d;
  logic             ovr_q, ovr_d;
  logic             pause_q;
  logic             pause_rise;
  logic             food_ok;
  logic             tick;
  logic             tick_en;
  logic [CNT_W-1:0] period_next;

  assign pause_rise = pause && !pause_q;
  // Collision wins over a tick on the same clock, so the counter stops too.
  assign tick_en    = (state_q == ST_RUN) && !collision;

  snake_tick_gen #(
    .CNT_W     (CNT_W),
    .TICK_BASE (TICK_BASE)
  ) u_tick_gen (
    .clock     (clock),
    .reset     (reset),
    .clear     (state_q == ST_IDLE),
    .enable    (tick_en),
    .period_in (period_next),
    .tick      (tick)
  );

  // Pause edge detector register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pause_q <= 1'b0;
    else        pause_q <= pause;
  end

  // State, request, direction and overrun registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      dir_q   <= DIR_NONE;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      dir_q   <= dir_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state and handshake logic.
  // Handshake: move_req rises one clock after a tick and holds, with
  // move_dir stable, until move_ack is sampled high; it drops at that edge
  // unless a tick lands on the same clock, which re-issues a new move.
  // A tick while a request is still pending is dropped and flagged in the
  // sticky overrun bit. Ack with no request pending is ignored.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    dir_d   = dir_q;
    ovr_d   = ovr_q;
    food_ok = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (dir_valid(direction)) state_d = ST_RUN;
      end
      ST_RUN, ST_PAUSE: begin
        if (collision) begin
          state_d = ST_OVER;
          req_d   = 1'b0;
        end else begin
          food_ok = food_eaten;
          if (pause_rise) state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
          if (tick) begin
            if (!req_q || move_ack) begin
              req_d = 1'b1;
              if (dir_valid(direction)) dir_d = direction;
            end else begin
              ovr_d = 1'b1;
            end
          end else if (req_q && move_ack) begin
            req_d = 1'b0;
          end
        end
      end
      default: begin
        req_d = 1'b0;
      end
    endcase
  end

`ifdef SNAKE_SPEEDUP_EN
  localparam int FOOD_W = (FOODS_PER_LEVEL > 1) ? $clog2(FOODS_PER_LEVEL) : 1;

  logic [FOOD_W-1:0]   food_q;
  logic [3:0]          level_q;
  logic [PERIOD_W-1:0] step_w;

  // Food counter and speed level; level saturates at MAX_LEVEL.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      food_q  <= '0;
      level_q <= '0;
    end else if (food_ok) begin
      if (food_q == FOOD_W'(FOODS_PER_LEVEL - 1)) begin
        food_q <= '0;
        if (level_q < 4'(MAX_LEVEL)) level_q <= level_q + 4'd1;
      end else begin
        food_q <= food_q + FOOD_W'(1);
      end
    end
  end

  // Period = max(TICK_BASE - level*TICK_STEP, TICK_MIN) without underflow.
  always_comb begin
    step_w = PERIOD_W'(level_q) * PERIOD_W'(TICK_STEP);
    if ((step_w + PERIOD_W'(TICK_MIN)) > PERIOD_W'(TICK_BASE))
      period_next = CNT_W'(TICK_MIN);
    else
      period_next = CNT_W'(PERIOD_W'(TICK_BASE) - step_w);
  end

  assign level = level_q;
`else
  localparam int unused_cfg = TICK_STEP + TICK_MIN + FOODS_PER_LEVEL + MAX_LEVEL + PERIOD_W;
  logic unused_food;

  assign unused_food = food_ok;
  assign period_next = CNT_W'(TICK_BASE);
  assign level       = 4'd0;
`endif

  assign move_req   = req_q;
  assign move_dir   = dir_q;
  assign game_state = state_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_snake_move_scheduler.sv
// Bench for snake_move_scheduler: directed scenarios plus randomized games,
// checked cycle by cycle against a behavioural model of the game rules.
module tb_snake_move_scheduler;

  localparam int TB_BASE  = 8;
  localparam int TB_STEP  = 2;
  localparam int TB_MIN   = 4;
  localparam int TB_FPL   = 2;
  localparam int TB_MAXL  = 15;
  localparam int TB_CNT_W = 24;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVER  = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] direction = 4'b1111;
  logic       pause = 1'b0;
  logic       food_eaten = 1'b0;
  logic       collision = 1'b0;
  logic       move_ack = 1'b0;
  logic       move_req;
  logic [3:0] move_dir;
  logic [1:0] game_state;
  logic [3:0] level;
  logic       overrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected {move_req, move_dir, game_state, level, overrun} per clock.
  logic [11:0] exp_q[$];

  // Reference model state.
  int         m_state, m_cnt, m_period, m_food, m_level;
  logic       m_req, m_ovr, m_pause_q;
  logic [3:0] m_dir;

  snake_move_scheduler #(
    .TICK_BASE       (TB_BASE),
    .TICK_STEP       (TB_STEP),
    .TICK_MIN        (TB_MIN),
    .FOODS_PER_LEVEL (TB_FPL),
    .MAX_LEVEL       (TB_MAXL),
    .CNT_W           (TB_CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .direction  (direction),
    .pause      (pause),
    .food_eaten (food_eaten),
    .collision  (collision),
    .move_ack   (move_ack),
    .move_req   (move_req),
    .move_dir   (move_dir),
    .game_state (game_state),
    .level      (level),
    .overrun    (overrun)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit is_valid(input logic [3:0] d);
    return (d == 4'b0001) || (d == 4'b0010) || (d == 4'b0100) || (d == 4'b1000);
  endfunction

  function automatic int period_for(input int lvl);
    int p;
    p = TB_BASE - lvl * TB_STEP;
    return (p < TB_MIN) ? TB_MIN : p;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_cnt = 0; m_period = TB_BASE; m_food = 0; m_level = 0;
    m_req = 1'b0; m_ovr = 1'b0; m_pause_q = 1'b0; m_dir = 4'b1111;
  endtask

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic [3:0] d, input logic p, input logic f,
                            input logic c, input logic a);
    bit rise;
    bit tick;
    rise = p && !m_pause_q;
    m_pause_q = p;
    tick = 0;
    if (m_state == M_IDLE) begin
      if (is_valid(d)) m_state = M_RUN;
    end else if (m_state == M_RUN || m_state == M_PAUSE) begin
      if (c) begin
        m_state = M_OVER;
        m_req = 1'b0;
      end else begin
        if (m_state == M_RUN) begin
          if (m_cnt == m_period - 1) begin
            tick = 1;
            m_cnt = 0;
            m_period = period_for(m_level);
          end else begin
            m_cnt++;
          end
        end
        if (tick && m_req && !a) m_ovr = 1'b1;
        else if (tick) begin
          m_req = 1'b1;
          if (is_valid(d)) m_dir = d;
        end else if (a) m_req = 1'b0;
`ifdef SNAKE_SPEEDUP_EN
        if (f) begin
          m_food++;
          if (m_food == TB_FPL) begin
            m_food = 0;
            if (m_level < TB_MAXL) m_level++;
          end
        end
`endif
        if (rise) m_state = (m_state == M_RUN) ? M_PAUSE : M_RUN;
      end
    end
  endtask

  task automatic push_exp();
    exp_q.push_back({m_req, m_dir, 2'(m_state), 4'(m_level), m_ovr});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic [3:0] d, input logic p, input logic f,
                      input logic c, input logic a);
    @(negedge clock);
    direction = d; pause = p; food_eaten = f; collision = c; move_ack = a;
    model_step(d, p, f, c, a);
    push_exp();
  endtask

  task automatic apply_reset(input bit check_async);
    @(negedge clock);
    #1;
    reset = 1'b0;
    direction = 4'b1111; pause = 1'b0; food_eaten = 1'b0; collision = 1'b0; move_ack = 1'b0;
    if (check_async) begin
      #1;
      n_tests++;
      if (move_req !== 1'b0 || move_dir !== 4'b1111 || game_state !== 2'b00 || overrun !== 1'b0) begin
        n_fail++;
        $display("FAIL async_reset: got req=%b dir=%b state=%b ovr=%b, want req=0 dir=1111 state=00 ovr=0",
                 move_req, move_dir, game_state, overrun);
      end
    end
    model_reset();
    push_exp();
    repeat (2) begin
      @(negedge clock);
      push_exp();
    end
    @(negedge clock);
    reset = 1'b1;
    model_step(direction, pause, food_eaten, collision, move_ack);
    push_exp();
  endtask

  task automatic run_until_cnt(input int target);
    for (int i = 0; i < 100; i++) begin
      if (m_state == M_RUN && m_cnt == target) break;
      step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic run_until_req();
    for (int i = 0; i < 100; i++) begin
      if (m_req) break;
      step(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  function automatic logic [3:0] rand_dir();
    case ($urandom_range(0, 5))
      0: return 4'b1111;
      1: return 4'b0001;
      2: return 4'b0010;
      3: return 4'b0100;
      4: return 4'b1000;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clock) begin
    logic [11:0] act;
    logic [11:0] exp_v;
    #2;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act = {move_req, move_dir, game_state, level, overrun};
      n_tests++;
      if (act !== exp_v) begin
        n_fail++;
        $display("FAIL outputs @%0t: got req=%b dir=%b state=%b level=%0d ovr=%b, want req=%b dir=%b state=%b level=%0d ovr=%b",
                 $time, act[11], act[10:7], act[6:5], act[4:1], act[0],
                 exp_v[11], exp_v[10:7], exp_v[6:5], exp_v[4:1], exp_v[0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    apply_reset(1'b0);

    // 1: start right, first move, ack, second move one interval later.
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);

    // 2: ack withheld for 20 clocks, direction changes must not leak in.
    for (int i = 0; i < 20; i++) step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);

    // 3: pause at counter 3, frozen for 50 clocks, resume.
    run_until_cnt(3);
    step(4'b0100, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 50; i++) step(4'b0100, (i < 5), 1'b0, 1'b0, 1'b0);
    step(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(4'b0100, 1'b0, 1'b0, 1'b0, (i == 6));

    // 4: collision on a tick clock, then everything ignored.
    run_until_cnt(TB_BASE - 1);
    step(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(rand_dir(), 1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);

    // 5: six food pulses with 2-clock gaps, then watch the period shrink.
    apply_reset(1'b0);
    step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(4'b0100, 1'b0, 1'b1, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
      step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 40; i++) step(4'b0100, 1'b0, 1'b0, 1'b0, 1'b1);

    // 6: idle with no or invalid direction, then async reset mid-request.
    apply_reset(1'b0);
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0011, 1'b0, 1'b1, 1'b1, 1'b0);
    step(4'b1000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_until_req();
    apply_reset(1'b1);

    // Randomized games.
    for (int g = 0; g < 8; g++) begin
      apply_reset(1'b0);
      for (int i = 0; i < 250; i++)
        step(rand_dir(),
             1'($urandom_range(0, 24) == 0),
             1'($urandom_range(0, 5) == 0),
             1'($urandom_range(0, 199) == 0),
             1'($urandom_range(0, 2) == 0));
    end

    @(posedge clock);
    #3;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
